// File: rtl/demorgan_pattern_checker.sv
// Clocked driver/checker for a two-input De Morgan gate: sweeps {a,b} = 00..11, samples c_in,
// counts mismatches. Define DEMORGAN_CHK_LOG_EN to capture the {a,b} of the first mismatch.
module demorgan_pattern_checker #(
  parameter int HOLD   = 2,
  parameter int PASSES = 1,
  parameter int FUNC   = 0,
  parameter int ERR_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             c_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       first_fail_ab,
  output logic             first_fail_vld
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD - 1);
  localparam logic [PW-1:0]    PASS_LAST = PW'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [PW-1:0]    pass_cnt_q, pass_cnt_d;
  logic [1:0]       ab_q, ab_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             expected;
  logic             mismatch;

`ifdef DEMORGAN_CHK_LOG_EN
  logic [1:0] ff_ab_q, ff_ab_d;
  logic       ff_vld_q, ff_vld_d;
`endif

  // Reference function of the gate under test, evaluated on the currently driven pattern.
  always_comb begin
    if (FUNC == 0) expected = ~(ab_q[1] & ab_q[0]);
    else           expected = ~(ab_q[1] | ab_q[0]);
    mismatch = (c_in != expected);
  end

  // NOTE: every signal gets its default first, so no path through the case leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    pass_cnt_d = pass_cnt_q;
    ab_d       = ab_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_cnt_d  = err_cnt_q;
`ifdef DEMORGAN_CHK_LOG_EN
    ff_ab_d    = ff_ab_q;
    ff_vld_d   = ff_vld_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_cnt_d  = '0;
          pass_d     = 1'b0;
          idx_d      = 2'd0;
          hold_cnt_d = '0;
          pass_cnt_d = '0;
          busy_d     = 1'b1;
          ab_d       = 2'b00;
          state_d    = S_RUN;
`ifdef DEMORGAN_CHK_LOG_EN
          ff_ab_d    = 2'b00;
          ff_vld_d   = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (hold_cnt_q == HOLD_LAST) begin
          if (mismatch) begin
            if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
`ifdef DEMORGAN_CHK_LOG_EN
            if (!ff_vld_q) begin
              ff_ab_d  = ab_q;
              ff_vld_d = 1'b1;
            end
`endif
          end
          hold_cnt_d = '0;
          idx_d      = idx_q + 2'd1;
          ab_d       = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            pass_cnt_d = pass_cnt_q + 1'b1;
            if (pass_cnt_q == PASS_LAST) begin
              ab_d    = 2'b00;
              state_d = S_DONE;
            end
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        // err_cnt_q already includes the final sample, taken on the edge into DONE.
        pass_d  = (err_cnt_q == '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      hold_cnt_q <= '0;
      pass_cnt_q <= '0;
      ab_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      ab_q       <= ab_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

`ifdef DEMORGAN_CHK_LOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_ab_q  <= '0;
      ff_vld_q <= 1'b0;
    end else begin
      ff_ab_q  <= ff_ab_d;
      ff_vld_q <= ff_vld_d;
    end
  end

  assign first_fail_ab  = ff_ab_q;
  assign first_fail_vld = ff_vld_q;
`else
  assign first_fail_ab  = 2'b00;
  assign first_fail_vld = 1'b0;
`endif

  assign a_out   = ab_q[1];
  assign b_out   = ab_q[0];
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_demorgan_pattern_checker.sv
// Bench for demorgan_pattern_checker: two instances (NAND/HOLD=2/PASSES=1/ERR_W=4 and
// NOR/HOLD=3/PASSES=2/ERR_W=2) driving gate models with per-pattern fault masks.
module tb_demorgan_pattern_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start0, start1;
  logic       a0, b0, a1, b1, c0, c1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [3:0] err0;
  logic [1:0] err1;
  logic [1:0] ffab0, ffab1;
  logic       ffv0, ffv1;
  logic [3:0] mask0, mask1;

  demorgan_pattern_checker #(.HOLD(2), .PASSES(1), .FUNC(0), .ERR_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .c_in(c0),
    .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .first_fail_ab(ffab0), .first_fail_vld(ffv0)
  );

  demorgan_pattern_checker #(.HOLD(3), .PASSES(2), .FUNC(1), .ERR_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .c_in(c1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .first_fail_ab(ffab1), .first_fail_vld(ffv1)
  );

  // Gate models: correct function, inverted for every pattern whose mask bit is set.
  always_comb c0 = ~(a0 & b0) ^ mask0[{a0, b0}];
  always_comb c1 = ~(a1 | b1) ^ mask1[{a1, b1}];

  int sel;
  logic [1:0] o_ab, o_ffab;
  logic [3:0] o_err;
  logic       o_busy, o_done, o_pass, o_ffv;
  always_comb begin
    if (sel == 1) begin
      o_ab = {a1, b1}; o_busy = busy1; o_done = done1; o_pass = pass1;
      o_err = {2'b00, err1}; o_ffab = ffab1; o_ffv = ffv1;
    end else begin
      o_ab = {a0, b0}; o_busy = busy0; o_done = done0; o_pass = pass0;
      o_err = err0; o_ffab = ffab0; o_ffv = ffv0;
    end
  end

  int n_checks = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 1) start1 = v;
    else        start0 = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ab"},   32'(o_ab),   0);
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_done"}, 32'(o_done), 0);
    check({tag, "_pass"}, 32'(o_pass), 0);
    check({tag, "_err"},  32'(o_err),  0);
    check({tag, "_ffab"}, 32'(o_ffab), 0);
    check({tag, "_ffv"},  32'(o_ffv),  0);
  endtask

  // One complete run. mode: 0 = start pulse, 1 = start held for the run, 2 = random start
  // toggling during the run (must be ignored). Expectations come from the fault mask alone.
  task automatic run(input int s, input logic [3:0] m, input int mode);
    int h, p, ew, n, maxv, exp_err;
    logic [1:0] exp_ff;
    logic       exp_vld;
    h  = (s == 1) ? 3 : 2;
    p  = (s == 1) ? 2 : 1;
    ew = (s == 1) ? 2 : 4;
    sel = s;
    if (s == 1) mask1 = m; else mask0 = m;
    n       = p * $countones(m);
    maxv    = (1 << ew) - 1;
    exp_err = (n > maxv) ? maxv : n;
    exp_ff  = 2'd0;
    for (int i = 3; i >= 0; i--) if (m[i]) exp_ff = 2'(i);
    exp_vld = (m != 4'd0);
`ifndef DEMORGAN_CHK_LOG_EN
    exp_ff  = 2'd0;
    exp_vld = 1'b0;
`endif
    @(negedge clk);
    set_start(s, 1'b1);
    @(posedge clk);
    for (int t = 0; t < 4 * h * p; t++) begin
      @(negedge clk);
      if (mode == 0)      set_start(s, 1'b0);
      else if (mode == 2) set_start(s, 1'($urandom_range(0, 1)));
      check("run_ab",   32'(o_ab),   32'((t / h) % 4));
      check("run_busy", 32'(o_busy), 1);
      check("run_done", 32'(o_done), 0);
      if (t == 0) begin
        check("start_err_clr",  32'(o_err),  0);
        check("start_pass_clr", 32'(o_pass), 0);
        check("start_ffv_clr",  32'(o_ffv),  0);
      end
    end
    @(negedge clk);
    set_start(s, 1'b0);
    check("pre_done", 32'(o_done), 0);
    check("pre_ab",   32'(o_ab),   0);
    @(negedge clk);
    check("done",      32'(o_done), 1);
    check("done_busy", 32'(o_busy), 0);
    check("done_pass", 32'(o_pass), 32'(exp_err == 0));
    check("done_err",  32'(o_err),  32'(exp_err));
    check("done_ffab", 32'(o_ffab), 32'(exp_ff));
    check("done_ffv",  32'(o_ffv),  32'(exp_vld));
    @(negedge clk);
    check("post_done", 32'(o_done), 0);
    check("post_busy", 32'(o_busy), 0);
    check("hold_err",  32'(o_err),  32'(exp_err));
    check("hold_pass", 32'(o_pass), 32'(exp_err == 0));
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    mask0 = 4'd0; mask1 = 4'd0; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1 check_all_zero("reset");
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(0, 4'b0000, 0);   // correct NAND
    run(0, 4'b1111, 0);   // c = a&b: every pattern wrong
    run(0, 4'b1000, 0);   // wrong only for a=b=1
    run(0, 4'b0000, 1);   // start held; err_cnt must clear first
    check("no_rerun_busy", 32'(busy0), 0);

    // Reset while idx=2: all outputs drop at once, no done pulse.
    sel = 0; mask0 = 4'b0010;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    start0 = 1'b0;
    check("rst_pre_ab", 32'(o_ab), 2);
    #1 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_done", 32'(o_done), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 4'b0000, 0);

    run(1, 4'b1111, 0);   // 8 mismatches, saturates at 3
    run(1, 4'b0000, 2);
    run(1, 4'b0100, 0);   // 2 mismatches over two passes

    for (int r = 0; r < 12; r++) begin
      int gap;
      run(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      check("gap_idle_busy", 32'(o_busy), 0);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
